// File: rtl/mem_pkg.sv
// Shared definitions for the multicycle core's unified memory unit.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_LATENCY = 3;
    localparam int unsigned WORD_BYTES      = 4;
    localparam int unsigned BYTE_OFF_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: write on the clock edge, read data follows the index.
module mem_array #(
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] index,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/multicycle_mem_unit.sv
// Unified instruction/data memory with a fixed multi-cycle access latency,
// one request in flight, and a one-cycle response strobe.
module multicycle_mem_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 16384,
    parameter int unsigned LATENCY   = DEFAULT_LATENCY,
    parameter int unsigned ADDR_W    = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        busy
);

    state_t            state;
    logic [3:0]        count;
    logic [ADDR_W-1:0] lat_idx;
    logic              lat_write;
    logic [31:0]       lat_wdata;
    logic              lat_mis;

    logic              accept;
    logic              enter_done;
    logic [ADDR_W-1:0] acc_idx;
    logic              acc_write;
    logic [31:0]       acc_wdata;
    logic              acc_mis;
    logic              mem_we;
    logic [31:0]       mem_rdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_W+BYTE_OFF_W];

    assign accept     = (state == S_IDLE) && req_valid;
    assign enter_done = ((state == S_WAIT) && (count == 4'd1)) ||
                        ((LATENCY == 1) && accept);

    // With LATENCY == 1 the access completes on the accepting edge, so the
    // live inputs must drive the array while idle instead of the latches.
    always_comb begin
        acc_idx   = lat_idx;
        acc_write = lat_write;
        acc_wdata = lat_wdata;
        acc_mis   = lat_mis;
        if (state == S_IDLE) begin
            acc_idx   = addr[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];
            acc_write = req_write;
            acc_wdata = wdata;
            acc_mis   = (addr[BYTE_OFF_W-1:0] != '0);
        end
    end

    // Gating with reset keeps an abandoned store from committing.
    assign mem_we = reset && enter_done && acc_write && !acc_mis;

    mem_array #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .index (acc_idx),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            count      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            rdata      <= '0;
            misaligned <= 1'b0;
            busy       <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            if (enter_done) begin
                resp_valid <= 1'b1;
                misaligned <= acc_mis;
                rdata      <= acc_mis ? '0 : (acc_write ? acc_wdata : mem_rdata);
            end
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_idx   <= addr[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];
                        lat_write <= req_write;
                        lat_wdata <= wdata;
                        lat_mis   <= (addr[BYTE_OFF_W-1:0] != '0);
                        count     <= 4'(LATENCY - 1);
                        state     <= (LATENCY == 1) ? S_DONE : S_WAIT;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_mem_unit.sv
// Randomized bench for multicycle_mem_unit: a LATENCY=3 and a LATENCY=1 instance
// checked against a word-addressed associative-array memory model.
module tb_multicycle_mem_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        sel = 1'b0;

    logic        rdy0, rv0, mis0, bsy0, rdy1, rv1, mis1, bsy1;
    logic [31:0] rd0, rd1;
    logic        vin0, vin1;
    logic        rdy, rv, mis, bsy;
    logic [31:0] rd;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mmem [int];

    always #5 clk = ~clk;

    assign vin0 = req_valid & ~sel;
    assign vin1 = req_valid & sel;
    assign rdy  = sel ? rdy1 : rdy0;
    assign rv   = sel ? rv1  : rv0;
    assign mis  = sel ? mis1 : mis0;
    assign bsy  = sel ? bsy1 : bsy0;
    assign rd   = sel ? rd1  : rd0;

    multicycle_mem_unit #(.MEM_DEPTH(16384), .LATENCY(3), .ADDR_W(14)) dut (
        .clk(clk), .reset(reset), .req_valid(vin0), .req_write(req_write),
        .addr(addr), .wdata(wdata), .req_ready(rdy0), .resp_valid(rv0),
        .rdata(rd0), .misaligned(mis0), .busy(bsy0)
    );

    multicycle_mem_unit #(.MEM_DEPTH(16384), .LATENCY(1), .ADDR_W(14)) dut_l1 (
        .clk(clk), .reset(reset), .req_valid(vin1), .req_write(req_write),
        .addr(addr), .wdata(wdata), .req_ready(rdy1), .resp_valid(rv1),
        .rdata(rd1), .misaligned(mis1), .busy(bsy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (sel=%0d t=%0t): got %h expected %h", tag, sel, $time, got, exp);
        end
    endtask

    // One request from the idle state through the first idle cycle after the response.
    // With keep set, a read of 0x10 stays asserted while the access is in flight.
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit keep);
        int unsigned lat;
        int          key;
        bit          exp_mis;
        bit          have_rd;
        logic [31:0] exp_rd;
        lat     = sel ? 1 : 3;
        key     = int'(sel) * 65536 + int'(a[15:2]);
        exp_mis = (a[1:0] != 2'b00);
        have_rd = 1'b1;
        exp_rd  = '0;
        if (!exp_mis) begin
            if (wr) begin
                exp_rd    = d;
                mmem[key] = d;
            end else if (mmem.exists(key)) begin
                exp_rd = mmem[key];
            end else begin
                have_rd = 1'b0;
            end
        end
        check_eq("ready_before", rdy, 1);
        req_valid = 1'b1;
        req_write = wr;
        addr      = a;
        wdata     = d;
        @(posedge clk); #1;
        req_valid = keep;
        req_write = keep ? 1'b0 : 1'($urandom_range(0, 1));
        addr      = keep ? 32'h10 : $urandom;
        wdata     = $urandom;
        for (int unsigned i = 1; i <= lat + 1; i++) begin
            if (i > 1) begin
                @(posedge clk); #1;
            end
            check_eq("resp_valid", rv, i == lat);
            check_eq("busy", bsy, i <= lat);
            check_eq("req_ready", rdy, i > lat);
            if (i >= lat) begin
                check_eq("misaligned", mis, exp_mis);
                if (have_rd) check_eq("rdata", rd, exp_rd);
            end
        end
    endtask

    task automatic check_idle_after_reset();
        check_eq("rst_ready", rdy, 1);
        check_eq("rst_resp_valid", rv, 0);
        check_eq("rst_rdata", rd, 0);
        check_eq("rst_misaligned", mis, 0);
        check_eq("rst_busy", bsy, 0);
    endtask

    initial begin
        logic [31:0] a;
        bit          wr;
        int unsigned w, lo;

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #0 check_idle_after_reset();
        end

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int k = 0; k < 16; k++) do_req(1'b1, 32'(k * 4), $urandom, 1'b0);
        end

        sel = 1'b0;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b1, 32'h20, 32'h12345678, 1'b0);
        do_req(1'b0, 32'h20, 32'h0, 1'b0);
        do_req(1'b1, 32'h22, 32'hFFFFFFFF, 1'b0);
        do_req(1'b0, 32'h20, 32'h0, 1'b0);
        do_req(1'b0, 32'h20, 32'h0, 1'b1);
        do_req(1'b0, 32'h10, 32'h0, 1'b0);

        do_req(1'b1, 32'h30, 32'h0, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b1;
        addr      = 32'h30;
        wdata     = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_idle_after_reset();
        for (int i = 0; i < 4; i++) begin
            check_eq("abandoned_resp", rv, 0);
            @(posedge clk); #1;
        end
        do_req(1'b0, 32'h30, 32'h0, 1'b0);

        sel = 1'b1;
        do_req(1'b1, 32'h4, 32'hA5A5_1234, 1'b0);
        do_req(1'b0, 32'h0001_0004, 32'h0, 1'b0);
        do_req(1'b0, 32'h0001_0004, 32'h0, 1'b1);
        do_req(1'b0, 32'h10, 32'h0, 1'b0);

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int n = 0; n < 40; n++) begin
                wr = 1'($urandom_range(0, 1));
                w  = $urandom_range(0, 15);
                lo = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                a  = ($urandom & 32'hFFFF_0000) | 32'(w * 4) | 32'(lo);
                do_req(wr, a, $urandom, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
